// File: rtl/perceptron_pkg.sv
// perceptron_pkg: shared FSM state type, accumulator sizing and signed saturation helpers.
package perceptron_pkg;

   typedef enum logic [1:0] {IDLE, ACC, OUT, UPDATE} state_t;

   // Room for N_IN+1 worst-case terms so the running sum can never wrap.
   function automatic int acc_width(int w, int n);
      return w + $clog2(n + 1);
   endfunction

   function automatic int sat_inc(int v, int w);
      return (v >= (1 << (w - 1)) - 1) ? v : v + 1;
   endfunction

   function automatic int sat_dec(int v, int w);
      return (v <= -(1 << (w - 1))) ? v : v - 1;
   endfunction

endpackage

// File: rtl/perceptron_sat_add.sv
// perceptron_sat_add: W-bit signed +1/-1 step that clamps at the two's-complement limits.
module perceptron_sat_add
   import perceptron_pkg::*;
#(
   parameter int W = 8
) (
   input  logic signed [W-1:0] a,
   input  logic                up,
   input  logic                en,
   output logic signed [W-1:0] y
);

   always_comb y = en ? W'(up ? sat_inc(int'(a), W) : sat_dec(int'(a), W)) : a;

endmodule

// File: rtl/perceptron_gate.sv
// perceptron_gate: single-neuron perceptron that learns an N_IN-input boolean gate on-chip,
// one input accumulated per cycle, weights nudged by +/-1 on each training error.
module perceptron_gate
   import perceptron_pkg::*;
#(
   parameter int N_IN      = 2,
   parameter int W_WIDTH   = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_IN-1:0]      e,
   input  logic                 target,
   input  logic                 train,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 clear,
   output logic                 s,
   output logic                 s_valid,
   output logic                 err,
   output logic [CNT_WIDTH-1:0] err_cnt
);

   localparam int ACC_W = acc_width(W_WIDTH, N_IN);
   localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;

   state_t                    state, state_nx;
   logic [N_IN-1:0]           e_r;
   logic                      tgt_r, trn_r;
   logic signed [W_WIDTH-1:0] w [N_IN];
   logic signed [W_WIDTH-1:0] w_nx [N_IN];
   logic signed [W_WIDTH-1:0] b, b_nx;
   logic signed [ACC_W-1:0]   acc, acc_nx;
   logic [IW-1:0]             idx;
   logic                      last, s_nx;

   assign in_ready = (state == IDLE) && !clear;
   assign s_valid  = (state == OUT);
   assign last     = (idx == IW'(N_IN - 1));
   assign acc_nx   = acc + (e_r[idx] ? ACC_W'(w[idx]) : '0);
   assign s_nx     = acc_nx > 0;

   for (genvar k = 0; k < N_IN; k++) begin : g_w
      perceptron_sat_add #(.W(W_WIDTH)) u_sat (.a(w[k]), .up(tgt_r), .en(e_r[k]), .y(w_nx[k]));
   end
   perceptron_sat_add #(.W(W_WIDTH)) u_sat_b (.a(b), .up(tgt_r), .en(1'b1), .y(b_nx));

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = (!clear && in_valid) ? ACC : IDLE;
         ACC:     state_nx = last ? OUT : ACC;
         OUT:     state_nx = err ? UPDATE : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // s and err are captured on the final accumulate so they are already valid in OUT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_r     <= '0;
         tgt_r   <= 1'b0;
         trn_r   <= 1'b0;
         w       <= '{default: '0};
         b       <= '0;
         acc     <= '0;
         idx     <= '0;
         s       <= 1'b0;
         err     <= 1'b0;
         err_cnt <= '0;
      end else begin
         unique case (state)
            IDLE:
               if (clear) begin
                  w       <= '{default: '0};
                  b       <= '0;
                  err_cnt <= '0;
               end else if (in_valid) begin
                  e_r   <= e;
                  tgt_r <= target;
                  trn_r <= train;
                  acc   <= ACC_W'(b);
                  idx   <= '0;
               end
            ACC: begin
               acc <= acc_nx;
               idx <= idx + IW'(1);
               if (last) begin
                  s   <= s_nx;
                  err <= trn_r && (s_nx != tgt_r);
               end
            end
            UPDATE: begin
               w <= w_nx;
               b <= b_nx;
               if (~&err_cnt) err_cnt <= err_cnt + CNT_WIDTH'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_perceptron_gate.sv
// tb_perceptron_gate: directed bench with a behavioural perceptron model feeding a scoreboard.
module tb_perceptron_gate;

   localparam int N = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  e = '0;
   logic          target = 1'b0, train = 1'b0, in_valid = 1'b0, clear = 1'b0;
   logic          in_ready, s, s_valid, err;
   logic [15:0]   err_cnt;

   logic signed [3:0] sa_a, sa_y;
   logic              sa_up, sa_en;

   int errors = 0, checks = 0;
   int mw[N];
   int mb = 0, mcnt = 0;
   logic [1:0] sb[$];

   always #5 clk = ~clk;

   perceptron_gate #(.N_IN(N), .W_WIDTH(8), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .e(e), .target(target), .train(train),
      .in_valid(in_valid), .in_ready(in_ready), .clear(clear),
      .s(s), .s_valid(s_valid), .err(err), .err_cnt(err_cnt)
   );

   perceptron_sat_add #(.W(4)) u_sat (.a(sa_a), .up(sa_up), .en(sa_en), .y(sa_y));

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int clamp8(input int v);
      return (v > 127) ? 127 : (v < -128) ? -128 : v;
   endfunction

   task automatic model(input logic [N-1:0] ev, input logic t, input logic tr, output logic ms, output logic me);
      int sum;
      sum = mb;
      for (int i = 0; i < N; i++) if (ev[i]) sum += mw[i];
      ms = sum > 0;
      me = tr && (ms != t);
      if (me) begin
         for (int i = 0; i < N; i++) if (ev[i]) mw[i] = clamp8(mw[i] + (t ? 1 : -1));
         mb = clamp8(mb + (t ? 1 : -1));
         mcnt++;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) mw[i] = 0;
      mb = 0;
      mcnt = 0;
   endtask

   // Inputs are scrambled right after acceptance to show only the accepted sample matters.
   task automatic run(input logic [N-1:0] ev, input logic t, input logic tr, input logic clr_mid, output logic got_err);
      logic ms, me, busy_bad;
      logic [1:0] exp;
      int lat;
      model(ev, t, tr, ms, me);
      sb.push_back({ms, me});
      @(negedge clk);
      lat = 0;
      while (!in_ready && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk("ready_before_accept", in_ready, 1);
      e = ev; target = t; train = tr; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0; e = ~ev; target = ~t; train = ~tr; clear = clr_mid;
      lat = 0;
      busy_bad = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (in_ready) busy_bad = 1'b1;
      end while (!s_valid && lat < 10);
      clear = 1'b0;
      chk("latency", lat, N + 1);
      chk("ready_low_busy", busy_bad, 0);
      exp = sb.pop_front();
      chk("s", s, exp[1]);
      chk("err", err, exp[0]);
      got_err = err;
      if (me) begin
         @(negedge clk);
         chk("ready_low_update", in_ready, 0);
      end
   endtask

   task automatic epoch(input logic [3:0] tg, input logic tr, output int nerr);
      logic ge;
      nerr = 0;
      for (int i = 0; i < 4; i++) begin
         run(i[N-1:0], tg[i], tr, 1'b0, ge);
         nerr += int'(ge);
      end
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1; in_valid = 1'b1; e = '1;
      #1 chk("clear_ready", in_ready, 0);
      @(posedge clk);
      #1 clear = 1'b0; in_valid = 1'b0;
      model_reset();
      @(negedge clk);
      chk("clear_w0", dut.w[0], 0);
      chk("clear_w1", dut.w[1], 0);
      chk("clear_b", dut.b, 0);
      chk("clear_cnt", err_cnt, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n, na, nv, cnt_save;
      int exp_or[4];
      logic ge;
      logic signed [3:0] st_a[6];
      logic st_up[6], st_en[6];
      logic signed [3:0] st_y[6];
      exp_or = '{1, 2, 1, 0};
      model_reset();
      sa_a = '0; sa_up = 1'b0; sa_en = 1'b0;
      #12;
      chk("rst_ready", in_ready, 1);
      chk("rst_s", s, 0);
      chk("rst_s_valid", s_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_cnt", err_cnt, 0);
      rst_n = 1'b1;

      for (int ep = 0; ep < 4; ep++) begin
         epoch(4'b1110, 1'b1, n);
         chk("or_epoch_errs", n, exp_or[ep]);
      end
      chk("or_cnt", err_cnt, 4);
      chk("or_w0", dut.w[0], 1);
      chk("or_w1", dut.w[1], 1);
      chk("or_b", dut.b, 0);
      epoch(4'b1110, 1'b0, n);
      chk("or_infer_cnt", err_cnt, 4);

      do_clear();
      run(2'b11, 1'b1, 1'b0, 1'b0, ge);
      chk("clear_s_11", s, 0);

      run(2'b01, 1'b1, 1'b1, 1'b0, ge);
      run(2'b10, 1'b1, 1'b0, 1'b1, ge);
      chk("clr_acc_cnt", err_cnt, 1);
      chk("clr_acc_w0", dut.w[0], 1);
      chk("clr_acc_b", dut.b, 1);

      @(negedge clk);
      e = 2'b11; train = 1'b0; in_valid = 1'b1;
      na = 0; nv = 0;
      for (int c = 0; c < 20; c++) begin
         if (in_valid && in_ready) na++;
         if (s_valid) begin
            nv++;
            chk("b2b_s", s, 1);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("b2b_accepts", na, 5);
      chk("b2b_results", nv, 5);

      do_clear();
      n = 1;
      for (int ep = 0; ep < 30 && n != 0; ep++) epoch(4'b1000, 1'b1, n);
      chk("and_converged", n, 0);
      cnt_save = int'(err_cnt);
      for (int i = 0; i < 4; i++) begin
         run(i[N-1:0], 1'b0, 1'b0, 1'b0, ge);
         chk("and_s", s, (i == 3) ? 1 : 0);
      end
      chk("and_infer_cnt", err_cnt, cnt_save);

      run(2'b00, 1'b1, 1'b1, 1'b0, ge);
      rst_n = 1'b0;
      #1;
      chk("arst_ready", in_ready, 1);
      chk("arst_s_valid", s_valid, 0);
      chk("arst_err", err, 0);
      chk("arst_s", s, 0);
      chk("arst_cnt", err_cnt, 0);
      chk("arst_w0", dut.w[0], 0);
      chk("arst_b", dut.b, 0);
      #10 rst_n = 1'b1;
      model_reset();

      st_a  = '{4'sd7, -4'sd8, 4'sd3, -4'sd8, 4'sd7, -4'sd5};
      st_up = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      st_en = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      st_y  = '{4'sd7, -4'sd8, 4'sd4, -4'sd7, 4'sd6, -4'sd5};
      for (int i = 0; i < 6; i++) begin
         sa_a = st_a[i]; sa_up = st_up[i]; sa_en = st_en[i];
         #1 chk("sat_add", sa_y, st_y[i]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
